// File: rtl/atomic_rmw_pkg.sv
// atomic_rmw_pkg: op encodings and field-width helpers shared by atomic_rmw_unit and its arbiter
package atomic_rmw_pkg;
    localparam int OP_W = 2;
    typedef enum logic [OP_W-1:0] {
        OP_INC  = 2'd0,
        OP_ADD  = 2'd1,
        OP_SWAP = 2'd2,
        OP_CAS  = 2'd3
    } op_e;
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter; one-hot grant plus index, pointer moves past each grant
module rr_arbiter #(
    parameter int NUM_CLIENTS = 4,
    parameter int CW          = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_CLIENTS-1:0] req,
    input  logic                   advance,
    output logic [NUM_CLIENTS-1:0] grant,
    output logic [CW-1:0]          grant_idx
);
    logic [CW-1:0] ptr;
    function automatic int slot(input logic [CW-1:0] p, input int k);
        return (int'(p) + k) % NUM_CLIENTS;
    endfunction
    // Scan from the farthest offset down so the client nearest the pointer wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
            if (req[slot(ptr, k)]) begin
                grant     = NUM_CLIENTS'(1) << slot(ptr, k);
                grant_idx = CW'(slot(ptr, k));
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= '0;
        else if (advance && |req)
            ptr <= (grant_idx == CW'(NUM_CLIENTS - 1)) ? '0 : grant_idx + 1'b1;
    end
endmodule

// File: rtl/atomic_rmw_unit.sv
// atomic_rmw_unit: multi-client atomic INC/ADD/SWAP/CAS on a counter array, one commit per cycle, 1-cycle response
// Define ATOMIC_RMW_SAT_EN to make INC/ADD saturate at all-ones instead of wrapping.
module atomic_rmw_unit
    import atomic_rmw_pkg::*;
#(
    parameter int NUM_CLIENTS = 4,
    parameter int NUM_CTRS    = 8,
    parameter int DATA_W      = 32,
    parameter int IDX_W       = 3,
    parameter int CID_W       = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_CLIENTS-1:0]        req_valid,
    output logic [NUM_CLIENTS-1:0]        req_ready,
    input  logic [OP_W*NUM_CLIENTS-1:0]   req_op,
    input  logic [IDX_W*NUM_CLIENTS-1:0]  req_idx,
    input  logic [DATA_W*NUM_CLIENTS-1:0] req_operand,
    input  logic [DATA_W*NUM_CLIENTS-1:0] req_compare,
    output logic                          rsp_valid,
    output logic [CID_W-1:0]              rsp_client,
    output logic [DATA_W-1:0]             rsp_value,
    output logic                          rsp_success,
    output logic                          rsp_err
);
    logic [NUM_CLIENTS-1:0] grant;
    logic [CID_W-1:0]       g;
    op_e                    op;
    logic [IDX_W-1:0]       idx;
    logic [DATA_W-1:0]      operand, compare, old, addend, add_val, new_val;
    logic                   in_range, cas_hit, fire;
    logic [DATA_W-1:0]      ctr [NUM_CTRS];
`ifdef ATOMIC_RMW_SAT_EN
    logic [DATA_W:0]        sum;
`endif
    rr_arbiter #(.NUM_CLIENTS(NUM_CLIENTS), .CW(CID_W)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_valid),
        .advance   (rst_n),
        .grant     (grant),
        .grant_idx (g)
    );
    assign req_ready = grant & {NUM_CLIENTS{rst_n}};
    assign fire      = |req_ready;
    // Single-cycle RMW straight off the register array, so back-to-back ops need no forwarding.
    always_comb begin
        op       = op_e'(req_op[g*OP_W +: OP_W]);
        idx      = req_idx[g*IDX_W +: IDX_W];
        operand  = req_operand[g*DATA_W +: DATA_W];
        compare  = req_compare[g*DATA_W +: DATA_W];
        in_range = int'(idx) < NUM_CTRS;
        old      = in_range ? ctr[idx] : '0;
        addend   = (op == OP_INC) ? DATA_W'(1) : operand;
`ifdef ATOMIC_RMW_SAT_EN
        sum      = {1'b0, old} + {1'b0, addend};
        add_val  = sum[DATA_W] ? '1 : sum[DATA_W-1:0];
`else
        add_val  = old + addend;
`endif
        cas_hit  = old == compare;
        new_val  = (op == OP_SWAP || (op == OP_CAS && cas_hit)) ? operand :
                   (op == OP_CAS) ? old : add_val;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CTRS; i++) ctr[i] <= '0;
            rsp_valid   <= 1'b0;
            rsp_client  <= '0;
            rsp_value   <= '0;
            rsp_success <= 1'b0;
            rsp_err     <= 1'b0;
        end else begin
            rsp_valid <= fire;
            if (fire) begin
                rsp_client  <= g;
                rsp_value   <= old;
                rsp_success <= in_range && (op != OP_CAS || cas_hit);
                rsp_err     <= !in_range;
                if (in_range) ctr[idx] <= new_val;
            end
        end
    end
endmodule

// File: tb/tb_atomic_rmw_unit.sv
// tb_atomic_rmw_unit: directed and randomized checks of atomic_rmw_unit against a behavioural counter model
module tb_atomic_rmw_unit;
    import atomic_rmw_pkg::*;
    localparam int NC = 4;
    localparam int NT = 6;
    localparam int DW = 32;
    localparam int IW = 3;
    localparam int CW = 2;
    logic clk, rst_n;
    logic [NC-1:0] req_valid, req_ready;
    logic [2*NC-1:0] req_op;
    logic [IW*NC-1:0] req_idx;
    logic [DW*NC-1:0] req_operand, req_compare;
    logic rsp_valid, rsp_success, rsp_err;
    logic [CW-1:0] rsp_client;
    logic [DW-1:0] rsp_value;
    atomic_rmw_unit #(.NUM_CLIENTS(NC), .NUM_CTRS(NT), .DATA_W(DW), .IDX_W(IW), .CID_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_idx(req_idx), .req_operand(req_operand), .req_compare(req_compare), .rsp_valid(rsp_valid),
        .rsp_client(rsp_client), .rsp_value(rsp_value), .rsp_success(rsp_success), .rsp_err(rsp_err)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    logic [NC-1:0] v;
    logic [1:0] op [NC];
    logic [2:0] ix [NC];
    logic [31:0] opd [NC];
    logic [31:0] cmp [NC];
    logic [31:0] m_ctr [8];
    int m_ptr;
    logic [NC-1:0] got_ready, exp_ready;
    logic exp_valid, exp_succ, exp_err;
    logic [CW-1:0] exp_client;
    logic [31:0] exp_value;
    int n_chk, n_pass;
    function automatic logic [31:0] add_m(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
`ifdef ATOMIC_RMW_SAT_EN
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
`else
        return s[31:0];
`endif
    endfunction
    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_ctr[i] = '0;
        m_ptr = 0;
    endtask
    task automatic drive();
        for (int c = 0; c < NC; c++) begin
            req_valid[c] = v[c];
            req_op[c*2 +: 2] = op[c];
            req_idx[c*IW +: IW] = ix[c];
            req_operand[c*DW +: DW] = opd[c];
            req_compare[c*DW +: DW] = cmp[c];
        end
    endtask
    // One clock from negedge to negedge: drive, sample ready, predict grant and response.
    task automatic step();
        int g;
        int c;
        logic [31:0] old;
        drive();
        #1;
        got_ready = req_ready;
        exp_ready = '0;
        exp_valid = 1'b0;
        g = -1;
        for (int k = 0; k < NC; k++) begin
            c = (m_ptr + k) % NC;
            if (g < 0 && v[c]) g = c;
        end
        if (g >= 0) begin
            exp_valid = 1'b1;
            exp_ready[g] = 1'b1;
            exp_client = 2'(g);
            m_ptr = (g + 1) % NC;
            v[g] = 1'b0;
            if (int'(ix[g]) >= NT) begin
                exp_err = 1'b1; exp_value = '0; exp_succ = 1'b0;
            end else begin
                old = m_ctr[ix[g]];
                exp_err = 1'b0; exp_value = old; exp_succ = 1'b1;
                case (op[g])
                    OP_INC:  m_ctr[ix[g]] = add_m(old, 32'd1);
                    OP_ADD:  m_ctr[ix[g]] = add_m(old, opd[g]);
                    OP_SWAP: m_ctr[ix[g]] = opd[g];
                    default: if (old == cmp[g]) m_ctr[ix[g]] = opd[g]; else exp_succ = 1'b0;
                endcase
            end
        end
        @(negedge clk);
    endtask
    task automatic req1(input int c, input logic [1:0] o, input logic [2:0] i, input logic [31:0] d, input logic [31:0] k);
        v[c] = 1'b1; op[c] = o; ix[c] = i; opd[c] = d; cmp[c] = k;
        step();
    endtask
    task automatic test_reset();
        v = '1;
        for (int c = 0; c < NC; c++) begin op[c] = OP_INC; ix[c] = 3'd0; opd[c] = '0; cmp[c] = '0; end
        drive();
        #12;
        n_chk++;
        if (req_ready !== '0) $display("FAIL reset ready: got %b want 0000", req_ready); else n_pass++;
        n_chk++;
        if ({rsp_valid, rsp_client, rsp_value, rsp_success, rsp_err} !== '0)
            $display("FAIL reset rsp: got v=%b c=%0d val=%h s=%b e=%b want all 0", rsp_valid, rsp_client, rsp_value, rsp_success, rsp_err);
        else n_pass++;
        v = '0;
        drive();
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask
    task automatic test_inc_seq();
        for (int i = 0; i < 4; i++) begin
            req1(0, OP_INC, 3'd2, 32'h0, 32'h0);
            n_chk++;
            if (got_ready !== 4'b0001) $display("FAIL inc_seq ready: got %b want 0001", got_ready); else n_pass++;
            n_chk++;
            if (rsp_valid !== 1'b1 || rsp_client !== 2'd0 || rsp_value !== 32'(i) || rsp_success !== 1'b1 || rsp_err !== 1'b0)
                $display("FAIL inc_seq rsp: got v=%b c=%0d val=%h s=%b e=%b want v=1 c=0 val=%h s=1 e=0",
                         rsp_valid, rsp_client, rsp_value, rsp_success, rsp_err, 32'(i));
            else n_pass++;
        end
    endtask
    task automatic test_rotation();
        int start, issued;
        int cnt [NC];
        start = m_ptr;
        issued = NC;
        for (int c = 0; c < NC; c++) begin cnt[c] = 0; v[c] = 1'b1; op[c] = OP_INC; ix[c] = 3'd0; opd[c] = '0; cmp[c] = '0; end
        for (int i = 0; i < 8; i++) begin
            step();
            n_chk++;
            if (got_ready !== exp_ready) $display("FAIL rotation ready: got %b want %b", got_ready, exp_ready); else n_pass++;
            n_chk++;
            if (rsp_valid !== 1'b1 || rsp_client !== 2'((start + i) % NC) || rsp_value !== 32'(i))
                $display("FAIL rotation rsp %0d: got v=%b c=%0d val=%h want v=1 c=%0d val=%h",
                         i, rsp_valid, rsp_client, rsp_value, (start + i) % NC, 32'(i));
            else n_pass++;
            if (rsp_valid === 1'b1) cnt[rsp_client]++;
            if (issued < 8) begin v[exp_client] = 1'b1; issued++; end
        end
        for (int c = 0; c < NC; c++) begin
            n_chk++;
            if (cnt[c] != 2) $display("FAIL rotation count client %0d: got %0d want 2", c, cnt[c]); else n_pass++;
        end
    endtask
    // Scripted single-client sequences: op, idx, operand, compare, required value, required success, required err.
    task automatic run_script(input string name, input int c, input int n,
                              input logic [1:0] so [4], input logic [2:0] si [4], input logic [31:0] sd [4],
                              input logic [31:0] sk [4], input logic [31:0] sv [4], input logic ss [4], input logic se [4]);
        for (int i = 0; i < n; i++) begin
            req1(c, so[i], si[i], sd[i], sk[i]);
            n_chk++;
            if (got_ready !== exp_ready) $display("FAIL %s ready: got %b want %b", name, got_ready, exp_ready); else n_pass++;
            n_chk++;
            if (rsp_valid !== 1'b1 || rsp_client !== 2'(c) || rsp_value !== sv[i] || rsp_success !== ss[i] || rsp_err !== se[i])
                $display("FAIL %s rsp %0d: got v=%b c=%0d val=%h s=%b e=%b want v=1 c=%0d val=%h s=%b e=%b",
                         name, i, rsp_valid, rsp_client, rsp_value, rsp_success, rsp_err, c, sv[i], ss[i], se[i]);
            else n_pass++;
        end
    endtask
    task automatic test_wrap();
        logic [31:0] last;
`ifdef ATOMIC_RMW_SAT_EN
        last = 32'hFFFF_FFFF;
`else
        last = 32'h1;
`endif
        run_script("wrap", 1, 4, '{OP_SWAP, OP_ADD, OP_INC, OP_INC}, '{3'd1, 3'd1, 3'd1, 3'd1},
                   '{32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0}, '{32'd0, 32'd0, 32'd0, 32'd0},
                   '{32'd0, 32'hFFFF_FFFF, last, add_m(last, 32'd1)}, '{1'b1, 1'b1, 1'b1, 1'b1}, '{1'b0, 1'b0, 1'b0, 1'b0});
    endtask
    task automatic test_cas();
        run_script("cas", 3, 4, '{OP_SWAP, OP_CAS, OP_CAS, OP_INC}, '{3'd3, 3'd3, 3'd3, 3'd3},
                   '{32'd5, 32'd9, 32'd7, 32'd0}, '{32'd0, 32'd5, 32'd5, 32'd0},
                   '{32'd0, 32'd5, 32'd9, 32'd9}, '{1'b1, 1'b1, 1'b0, 1'b1}, '{1'b0, 1'b0, 1'b0, 1'b0});
    endtask
    task automatic test_err();
        run_script("err", 2, 4, '{OP_ADD, OP_SWAP, OP_CAS, OP_INC}, '{3'd7, 3'd6, 3'd7, 3'd5},
                   '{32'd5, 32'd77, 32'd1, 32'd0}, '{32'd0, 32'd0, 32'd0, 32'd0},
                   '{32'd0, 32'd0, 32'd0, 32'd0}, '{1'b0, 1'b0, 1'b0, 1'b1}, '{1'b1, 1'b1, 1'b1, 1'b0});
    endtask
    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < NC; c++) begin
                if (!v[c] && i < 380 && $urandom_range(0, 2) != 0) begin
                    v[c] = 1'b1;
                    op[c] = 2'($urandom_range(0, 3));
                    ix[c] = 3'($urandom_range(0, 7));
                    opd[c] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 3) : $urandom;
                    cmp[c] = ($urandom_range(0, 1) == 0) ? m_ctr[ix[c]] : $urandom;
                end
            end
            step();
            n_chk++;
            if (got_ready !== exp_ready) $display("FAIL random ready %0d: got %b want %b", i, got_ready, exp_ready); else n_pass++;
            n_chk++;
            if (rsp_valid !== exp_valid || (exp_valid && (rsp_client !== exp_client || rsp_value !== exp_value ||
                rsp_success !== exp_succ || rsp_err !== exp_err)))
                $display("FAIL random rsp %0d: got v=%b c=%0d val=%h s=%b e=%b want v=%b c=%0d val=%h s=%b e=%b",
                         i, rsp_valid, rsp_client, rsp_value, rsp_success, rsp_err,
                         exp_valid, exp_client, exp_value, exp_succ, exp_err);
            else n_pass++;
        end
        n_chk++;
        if (v !== '0) $display("FAIL random drain: pending %b want 0000", v); else n_pass++;
    endtask
    task automatic test_mid_reset();
        v[0] = 1'b1; op[0] = OP_INC; ix[0] = 3'd4; opd[0] = '0; cmp[0] = '0;
        drive();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (rsp_valid !== 1'b0) $display("FAIL mid_reset rsp_valid: got %b want 0", rsp_valid); else n_pass++;
        v = '0;
        drive();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            n_chk++;
            if (rsp_valid !== 1'b0 || got_ready !== '0)
                $display("FAIL mid_reset idle %0d: got v=%b ready=%b want v=0 ready=0000", i, rsp_valid, got_ready);
            else n_pass++;
        end
        for (int t = 0; t < NT; t++) begin
            req1(2, OP_INC, 3'(t), 32'd0, 32'd0);
            n_chk++;
            if (rsp_valid !== 1'b1 || rsp_client !== 2'd2 || rsp_value !== 32'd0 || rsp_err !== 1'b0)
                $display("FAIL mid_reset ctr %0d: got v=%b c=%0d val=%h e=%b want v=1 c=2 val=0 e=0",
                         t, rsp_valid, rsp_client, rsp_value, rsp_err);
            else n_pass++;
        end
    endtask
    initial begin
        n_chk = 0;
        n_pass = 0;
        rst_n = 1'b0;
        v = '0;
        for (int c = 0; c < NC; c++) begin op[c] = '0; ix[c] = '0; opd[c] = '0; cmp[c] = '0; end
        model_reset();
        drive();
        test_reset();
        test_inc_seq();
        test_rotation();
        test_wrap();
        test_cas();
        test_err();
        test_random();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/atomic_rmw_unit.md
Name: atomic_rmw_unit

Overview:
Multi-client, multi-counter atomic read-modify-write unit for wait-free synchronisation primitives such as ticket counters, work-queue heads and barrier counts. It generalises single-counter fetch-and-increment to:
- NUM_CLIENTS requesters with an internal round-robin arbiter;
- NUM_CTRS independent counters;
- four operations: INC, ADD, SWAP, CAS.

One operation commits per cycle. Service latency is bounded, which makes every client wait-free. The unit sits between the SM-side atomic request crossbar and the synchronisation scoreboard.

Parameters:
NUM_CLIENTS, 4, number of requesting ports (>=1)
NUM_CTRS, 8, number of counters (>=1, need not be a power of two)
DATA_W, 32, counter/operand width in bits
IDX_W, 3, counter index width (>=1; must address NUM_CTRS)
CID_W, 2, client-id width (>=1; must encode NUM_CLIENTS)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_CLIENTS  per-client request valid
req_ready  out  NUM_CLIENTS  per-client accept, one-hot or zero
req_op  in  2*NUM_CLIENTS  per-client op: 0=INC 1=ADD 2=SWAP 3=CAS
req_idx  in  IDX_W*NUM_CLIENTS  per-client counter index
req_operand  in  DATA_W*NUM_CLIENTS  ADD addend / SWAP value / CAS new value
req_compare  in  DATA_W*NUM_CLIENTS  CAS expected value
rsp_valid  out  1  one-cycle pulse, response valid
rsp_client  out  CID_W  client that owns the response
rsp_value  out  DATA_W  counter value before the op
rsp_success  out  1  CAS matched (always 1 for INC/ADD/SWAP)
rsp_err  out  1  index >= NUM_CTRS; no update performed

Behaviour:
- Reset (async, rst_n low):
  - all counters = 0; rr pointer = 0;
  - rsp_valid=0, rsp_client=0, rsp_value=0, rsp_success=0, rsp_err=0;
  - req_ready=0 while in reset.
- Arbitration:
  - Combinational round-robin over req_valid, starting at the pointer.
  - req_ready = one-hot grant.
  - On grant of client g, the pointer becomes (g+1) mod NUM_CLIENTS at the clock edge.
  - Pointer is unchanged when there is no request.
- Handshake:
  - Transfer occurs when req_valid[i] & req_ready[i].
  - A client holds valid and its fields stable until accepted.
  - A client may drop valid only after acceptance.
- Commit and latency:
  - The counter update commits at the accepting edge.
  - The response is registered and appears on the next cycle: 1-cycle latency.
  - rsp_valid is high for exactly one cycle per accepted request.
  - Bounded wait: a continuously valid client is accepted within NUM_CLIENTS cycles.
- Ops (old = ctr[idx]):
  - INC: ctr = old+1
  - ADD: ctr = old+operand
  - SWAP: ctr = operand
  - CAS: if old==compare then ctr=operand, success=1; else unchanged, success=0
- Arithmetic: modulo 2^DATA_W; all-ones wraps to 0.
- Back-to-back to the same counter: the second op sees the first's result. The counter reads the register directly and the RMW is single-cycle, so no forwarding hazard exists.
- Out-of-range index:
  - Request is accepted.
  - No counter changes.
  - rsp_err=1, rsp_value=0, rsp_success=0.
- Reset asserted mid-operation: the pending response is discarded and no rsp_valid is produced after reset releases.
- Only one commit per cycle, so there is no simultaneous-write case. Non-granted clients see req_ready=0 and retry automatically by holding valid.

Optional Feature:
ATOMIC_RMW_SAT_EN
- Defined: INC and ADD saturate at 2^DATA_W-1 instead of wrapping. A saturated op still returns old, with rsp_success=1.
- Undefined: modulo wrap as described in Behaviour.
- SWAP and CAS are unaffected in both cases.

Decomposition:
- Package atomic_rmw_pkg:
  - op encodings OP_INC/OP_ADD/OP_SWAP/OP_CAS;
  - op field width 2;
  - response-field width helpers.
- Sub-module rr_arbiter, parametrised by NUM_CLIENTS: inputs req and advance; outputs one-hot grant and grant index. Reused by other sync blocks.
- Counter array and op ALU stay in the top module.

Test Plan:
- Reset, then client0 issues INC on idx2 three times → rsp_value 0,1,2 on successive responses; ctr2=3; rsp_client=0.
- All 4 clients hold INC on idx0 for 8 cycles → grants rotate 0,1,2,3,0,1,2,3; rsp_values 0..7 unique; each client gets exactly 2 responses.
- Wrap and saturation, from ctr1=0xFFFFFFFF after SWAP:
  - ADD 2 → rsp_value 0xFFFFFFFF, then ctr1=1;
  - with ATOMIC_RMW_SAT_EN defined, ctr1 stays 0xFFFFFFFF.
- CAS on idx3=5:
  - compare=5, new=9 → success=1, ctr3=9;
  - then compare=5 → success=0, rsp_value=9, ctr3 unchanged.
- NUM_CTRS=6, request idx7 → accepted; rsp_err=1, rsp_value=0; no counter changes.
- Assert rst_n low in the cycle after an accept → no rsp_valid afterwards; all counters read 0 on subsequent INCs.
